// File: rtl/send_kernel.sv
// UART 8N1 packet transmitter: latches a 72-bit word and sends NUM_BYTES frames, byte 0 first.
// Define SEND_KERNEL_CHECKSUM_EN to append a modulo-256 checksum frame after the payload.
module send_kernel #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int NUM_BYTES = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        start,
  input  logic [71:0] data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef SEND_KERNEL_CHECKSUM_EN
  localparam int LAST_IDX = NUM_BYTES;
`else
  localparam int LAST_IDX = NUM_BYTES - 1;
`endif

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   baudCnt_q, baudCnt_d;
  logic [2:0]         bitCnt_q, bitCnt_d;
  logic [3:0]         byteIdx_q, byteIdx_d;
  logic [7:0]         shiftReg_q, shiftReg_d;
  logic [71:0]        dataReg_q, dataReg_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               bitEnd;
  logic [3:0]         nextIdx;
  logic [7:0]         nextByte;

`ifdef SEND_KERNEL_CHECKSUM_EN
  logic [7:0]         checksum;

  always_comb begin
    checksum = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      checksum = checksum + dataReg_q[8*k +: 8];
    end
  end
`endif

  always_comb begin
    nextIdx  = byteIdx_q + 4'd1;
    nextByte = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (nextIdx == 4'(k)) nextByte = dataReg_q[8*k +: 8];
    end
`ifdef SEND_KERNEL_CHECKSUM_EN
    if (nextIdx == 4'(NUM_BYTES)) nextByte = checksum;
`endif
  end

  assign bitEnd = (baudCnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    baudCnt_d  = baudCnt_q;
    bitCnt_d   = bitCnt_q;
    byteIdx_d  = byteIdx_q;
    shiftReg_d = shiftReg_q;
    dataReg_d  = dataReg_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is deliberately dropped.
        if (start && we && !done_q) begin
          dataReg_d  = data;
          shiftReg_d = data[7:0];
          byteIdx_d  = 4'd0;
          baudCnt_d  = '0;
          bitCnt_d   = 3'd0;
          state_d    = START_BIT;
        end
      end
      START_BIT: begin
        if (bitEnd) begin
          baudCnt_d = '0;
          bitCnt_d  = 3'd0;
          state_d   = DATA_BITS;
        end else begin
          baudCnt_d = baudCnt_q + CNT_W'(1);
        end
      end
      DATA_BITS: begin
        if (bitEnd) begin
          baudCnt_d  = '0;
          shiftReg_d = shiftReg_q >> 1;
          if (bitCnt_q == 3'd7) begin
            state_d = STOP_BIT;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end else begin
          baudCnt_d = baudCnt_q + CNT_W'(1);
        end
      end
      STOP_BIT: begin
        if (bitEnd) begin
          baudCnt_d = '0;
          if (byteIdx_q == 4'(LAST_IDX)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            byteIdx_d  = nextIdx;
            shiftReg_d = nextByte;
            bitCnt_d   = 3'd0;
            state_d    = START_BIT;
          end
        end else begin
          baudCnt_d = baudCnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Dropping we truncates the frame in flight; the receiver sees a framing error.
    if (!we) begin
      state_d   = IDLE;
      baudCnt_d = '0;
      bitCnt_d  = 3'd0;
      byteIdx_d = 4'd0;
      done_d    = 1'b0;
    end
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      IDLE:      tx_d = 1'b1;
      START_BIT: tx_d = 1'b0;
      DATA_BITS: tx_d = shiftReg_d[0];
      STOP_BIT:  tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baudCnt_q  <= '0;
      bitCnt_q   <= 3'd0;
      byteIdx_q  <= 4'd0;
      shiftReg_q <= 8'h00;
      dataReg_q  <= 72'h0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baudCnt_q  <= baudCnt_d;
      bitCnt_q   <= bitCnt_d;
      byteIdx_q  <= byteIdx_d;
      shiftReg_q <= shiftReg_d;
      dataReg_q  <= dataReg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/send_kernel.md
Name: send_kernel

Overview:
- UART transmit counterpart of the 9-byte kernel/pixel receive path.
- Latches a 72-bit word (3x3 kernel or 9 result pixels, one byte each) on a start pulse.
- Serialises the word as NUM_BYTES back-to-back 8N1 UART frames on tx, byte 0 (data[7:0]) first.
- Built-in baud generator and bit engine; sits between the convolution result path and the board UART pin.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide), must be >= 2.
- NUM_BYTES, 9, bytes per packet, 1..9. Byte k = data[8k+7:8k].

Ports:
- clk    input   1   system clock, rising edge.
- rst    input   1   asynchronous, active-high reset.
- we     input   1   enable. Low aborts any packet and holds the block idle.
- start  input   1   one-cycle request. Sampled only when idle and we=1.
- data   input   72  packet payload. Latched on the accepted start cycle.
- tx     output  1   UART serial line, idle high.
- busy   output  1   high from the cycle after start is accepted until the packet completes.
- done   output  1   one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset values: tx=1, busy=0, done=0, state=IDLE, all counters 0, shift register 0.
- Reset is asynchronous: asserting rst mid-frame forces tx=1 immediately. No done pulse is issued and there is no resume.
- State machine: IDLE -> START_BIT -> DATA_BITS -> STOP_BIT -> (NEXT_BYTE -> START_BIT | FINISH) -> IDLE.
- IDLE:
  - tx=1.
  - start=1 and we=1 at edge N: latch data, byte_idx=0, enter START_BIT. tx=0 and busy=1 from edge N.
- START_BIT: tx=0 for CLKS_PER_BIT cycles, then DATA_BITS.
- DATA_BITS:
  - 8 bits sent LSB first, each held CLKS_PER_BIT cycles.
  - Driven from the shift register; bit_cnt runs 0..7.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles.
  - If byte_idx < NUM_BYTES-1: increment byte_idx, load the next byte, and enter START_BIT directly. There is no idle gap between frames.
  - Otherwise enter IDLE.
- Completion: done=1 and busy=0 on the same edge that returns to IDLE. done stays high exactly one cycle.
- Timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Packet length is NUM_BYTES*10*CLKS_PER_BIT cycles, measured from the start-accept edge to the done edge.
- Baud counter: counts 0..CLKS_PER_BIT-1 and clears on each bit boundary and on every state entry. There is no fractional correction.
- start while busy: ignored, with no queuing and no effect on the packet in flight.
- start in the same cycle done is asserted: ignored. A new start is accepted from the cycle after done.
- data changes after the accept edge: no effect on the packet in flight.
- we=0 at any time:
  - Synchronous abort: next edge goes to IDLE, tx=1, busy=0, done=0.
  - The partial frame is truncated. The receiver sees a framing error, which is accepted.
- we=0 together with start: start is not accepted.

Optional Feature:
- Macro: SEND_KERNEL_CHECKSUM_EN.
- Defined:
  - One extra frame follows byte NUM_BYTES-1.
  - Its payload is the 8-bit modulo-256 sum of all payload bytes.
  - Packet length becomes (NUM_BYTES+1)*10*CLKS_PER_BIT cycles.
  - done fires after the checksum stop bit.
- Undefined: exactly NUM_BYTES frames are sent and no checksum logic is present.

Test Plan:
- Reset value and async reset (CLK_FREQ=400, BAUD=100, so CLKS_PER_BIT=4; we=1):
  - After rst: tx=1, busy=0, done=0.
  - Assert rst mid-DATA_BITS: tx=1 within the same cycle, busy=0, no done.
- Nominal packet:
  - Stimulus: start pulse with data=72'h090807060504030201.
  - tx decodes to bytes 01,02,...,09 in order, each frame 0 + LSB-first bits + 1, each bit 4 cycles.
  - done at exactly 360 cycles after the accept edge; busy high for cycles 1..360.
- Back-to-back framing with data=72'hFF00FF00FF00FF00FF:
  - Stop bit of frame k is followed immediately by the start bit of frame k+1, with no extra high cycles.
  - Each bit is 4 cycles.
- start and data while busy:
  - Pulse start with data=72'h0 at cycle 100 of a packet: ignored, original bytes still sent, a single done.
  - Restart on the cycle after done: accepted, and tx goes low on that edge.
- we abort:
  - Drop we at cycle 150: tx=1 and busy=0 on the next edge, no done.
  - Raise we and start again: a full 9-byte packet is sent correctly.
- SEND_KERNEL_CHECKSUM_EN:
  - Stimulus: data=72'h090807060504030201.
  - A 10th byte 0x2D is sent; done at cycle 400.
  - With data=72'hFFFFFFFFFFFFFFFFFF the checksum byte is 0xF7.
